priority_arbiter_4: RTL and testbench

PRIORITY_ARBITER_4 -- requirements
Module: priority_arbiter_4

---
 rtl/arb_pkg.sv | 27 ++
 rtl/prio_enc4.sv | 31 +++
 rtl/priority_arbiter_4.sv | 131 +++++++++++++
 tb/tb_priority_arbiter_4.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the 4-way priority arbiter:
//   - arb_state_e : FSM state encodings (ST_IDLE = no owner, ST_BUSY = owner held)
//   - NUM_REQ     : number of requesters (4)
//   - IDX_W       : width of a requester index (2)
//   - rotr4       : circular right rotate of a 4-bit request vector
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Rotate right by sh: bit k of the result is bit (k + sh) mod 4 of vec.
    function automatic logic [NUM_REQ-1:0] rotr4(input logic [NUM_REQ-1:0] vec,
                                                 input logic [IDX_W-1:0]   sh);
        logic [2*NUM_REQ-1:0] dbl;
        dbl   = {vec, vec} >> sh;
        rotr4 = dbl[NUM_REQ-1:0];
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// ---------------------------------------------------------------------------
// prio_enc4
// Combinational 4-input priority encoder; the highest set index wins.
// Ports:
//   vec   : input  [3:0] request vector
//   idx   : output [1:0] index of the highest set bit (0 when vec is zero)
//   valid : output       high when any bit of vec is set
// ---------------------------------------------------------------------------
module prio_enc4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Highest-index-first encoding.
    always_comb begin
        valid = |vec;
        if (vec[3]) begin
            idx = 2'd3;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
    end

endmodule

// File: rtl/priority_arbiter_4.sv
// ---------------------------------------------------------------------------
// priority_arbiter_4
// Four-requester arbiter with grant holding, an optional per-owner hold limit
// and either fixed (index 3 highest) or rotating priority.
// Parameters:
//   RR       : 0 = fixed priority, 1 = rotating priority
//   MAX_HOLD : maximum consecutive grant cycles per owner (0 = unlimited)
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : [3:0] request per requester
//   gnt       : [3:0] one-hot grant (registered)
//   gnt_id    : [1:0] index of the granted requester (registered)
//   gnt_valid : high while a grant is active (registered)
// ---------------------------------------------------------------------------
module priority_arbiter_4
    import arb_pkg::*;
#(
    parameter int RR       = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_valid
);

    // A zero-width counter is not legal, so the disabled-limit case keeps one bit.
    localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_e          state_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [IDX_W-1:0]    gnt_id_r;
    logic                gnt_valid_r;
    logic [CW-1:0]       hold_cnt_r;
    logic [IDX_W-1:0]    last_owner_r;

    logic [NUM_REQ-1:0]  owner_mask_s;
    logic                others_s;
    logic                limit_hit_s;
    logic                keep_s;
    logic [NUM_REQ-1:0]  elig_s;
    logic [IDX_W-1:0]    shift_s;
    logic [NUM_REQ-1:0]  rot_s;
    logic [IDX_W-1:0]    enc_idx_s;
    logic                enc_valid_s;
    logic [IDX_W-1:0]    winner_s;

    // Owner-keep decision and eligible/rotated request vector for arbitration.
    always_comb begin
        owner_mask_s = 4'b0001 << gnt_id_r;
        others_s     = |(req & ~owner_mask_s);
        limit_hit_s  = (MAX_HOLD != 0) && (hold_cnt_r == CW'(MAX_HOLD));
        keep_s       = (state_r == ST_BUSY) && req[gnt_id_r] && !(limit_hit_s && others_s);
        // In BUSY the owner either released or hit the limit; either way it
        // sits out this arbitration round.
        if (state_r == ST_BUSY) begin
            elig_s = req & ~owner_mask_s;
        end else begin
            elig_s = req;
        end
        // Rotating by last_owner puts (last_owner - 1) at the top encoder slot.
        if (RR != 0) begin
            shift_s = last_owner_r;
        end else begin
            shift_s = 2'd0;
        end
        rot_s = rotr4(elig_s, shift_s);
    end

    prio_enc4 u_enc (
        .vec   (rot_s),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    // Undo the rotation to get the real requester index (2-bit wraparound).
    assign winner_s = enc_idx_s + shift_s;

    // Arbiter FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            gnt_r        <= 4'b0000;
            gnt_id_r     <= 2'd0;
            gnt_valid_r  <= 1'b0;
            hold_cnt_r   <= '0;
            last_owner_r <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_BUSY: begin
                    if (keep_s) begin
                        // Count saturates at the limit when nobody else waits.
                        if ((MAX_HOLD != 0) && (hold_cnt_r != CW'(MAX_HOLD))) begin
                            hold_cnt_r <= hold_cnt_r + CW'(1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end else if (enc_valid_s) begin
                        state_r      <= ST_BUSY;
                        gnt_r        <= 4'b0001 << winner_s;
                        gnt_id_r     <= winner_s;
                        gnt_valid_r  <= 1'b1;
                        hold_cnt_r   <= CW'(1);
                        last_owner_r <= winner_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        gnt_r       <= 4'b0000;
                        gnt_id_r    <= 2'd0;
                        gnt_valid_r <= 1'b0;
                        hold_cnt_r  <= '0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    gnt_r       <= 4'b0000;
                    gnt_id_r    <= 2'd0;
                    gnt_valid_r <= 1'b0;
                    hold_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;

endmodule

// File: tb/tb_priority_arbiter_4.sv
// ---------------------------------------------------------------------------
// tb_priority_arbiter_4
// Directed bench for priority_arbiter_4. Four instances cover the parameter
// sets of interest; each has its own request input, clock and reset are shared.
// Observed value per instance is packed as {gnt_valid, gnt_id, gnt}.
// ---------------------------------------------------------------------------
module tb_priority_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_fix, req_lim, req_rr, req_sat;
    logic [3:0] g_fix, g_lim, g_rr, g_sat;
    logic [1:0] id_fix, id_lim, id_rr, id_sat;
    logic       v_fix, v_lim, v_rr, v_sat;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    priority_arbiter_4 #(.RR(0), .MAX_HOLD(8)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req_fix),
        .gnt(g_fix), .gnt_id(id_fix), .gnt_valid(v_fix));
    priority_arbiter_4 #(.RR(0), .MAX_HOLD(3)) u_lim (
        .clk(clk), .rst_n(rst_n), .req(req_lim),
        .gnt(g_lim), .gnt_id(id_lim), .gnt_valid(v_lim));
    priority_arbiter_4 #(.RR(1), .MAX_HOLD(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_rr),
        .gnt(g_rr), .gnt_id(id_rr), .gnt_valid(v_rr));
    priority_arbiter_4 #(.RR(0), .MAX_HOLD(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req(req_sat),
        .gnt(g_sat), .gnt_id(id_sat), .gnt_valid(v_sat));

    // Expected packed output for an active grant to requester id.
    function automatic logic [6:0] exp_gnt(input logic [1:0] id);
        logic [3:0] one;
        one = 4'b0001 << id;
        return {1'b1, id, one};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_fix = 4'b0000;
        req_lim = 4'b0000;
        req_rr  = 4'b0000;
        req_sat = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Expected owner sequences for the constant-request tests.
    logic [1:0] lim_seq [10] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [1:0] rr_seq  [6]  = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};

    initial begin
        // Reset state of every instance.
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_fix", {v_fix, id_fix, g_fix}, 7'h00);
        check("rst_lim", {v_lim, id_lim, g_lim}, 7'h00);
        check("rst_rr",  {v_rr,  id_rr,  g_rr},  7'h00);
        check("rst_sat", {v_sat, id_sat, g_sat}, 7'h00);

        // Idle stays idle, then first grant after one edge.
        do_reset();
        tick();
        check("idle_hold", {v_fix, id_fix, g_fix}, 7'h00);
        req_fix = 4'b0101;
        tick();
        check("first_gnt", {v_fix, id_fix, g_fix}, exp_gnt(2'd2));
        req_fix = 4'b0000;
        tick();
        check("release_idle", {v_fix, id_fix, g_fix}, 7'h00);

        // Hold with no preemption, then handover without a bubble.
        req_fix = 4'b0010;
        tick();
        check("own1", {v_fix, id_fix, g_fix}, exp_gnt(2'd1));
        req_fix = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold1", {v_fix, id_fix, g_fix}, exp_gnt(2'd1));
        end
        req_fix = 4'b1000;
        tick();
        check("handover3", {v_fix, id_fix, g_fix}, exp_gnt(2'd3));

        // Hold limit 3 alternating between requesters 1 and 0.
        do_reset();
        req_lim = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("lim%0d", i), {v_lim, id_lim, g_lim}, exp_gnt(lim_seq[i]));
        end

        // Re-grant after release restarts the hold count.
        req_lim = 4'b0010;
        tick();
        tick();
        req_lim = 4'b0000;
        tick();
        check("lim_idle", {v_lim, id_lim, g_lim}, 7'h00);
        req_lim = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("regrant%0d", i), {v_lim, id_lim, g_lim}, exp_gnt(2'd1));
        end
        tick();
        check("regrant_sw", {v_lim, id_lim, g_lim}, exp_gnt(2'd0));

        // Rotating priority with limit 1.
        do_reset();
        req_rr = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr%0d", i), {v_rr, id_rr, g_rr}, exp_gnt(rr_seq[i]));
        end

        // Lone requester saturates, then reset mid-grant.
        do_reset();
        req_sat = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("sat%0d", i), {v_sat, id_sat, g_sat}, exp_gnt(2'd2));
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("async_drop", {v_sat, id_sat, g_sat}, 7'h00);
        tick();
        check("in_reset", {v_sat, id_sat, g_sat}, 7'h00);
        rst_n = 1'b1;
        tick();
        check("post_reset", {v_sat, id_sat, g_sat}, exp_gnt(2'd2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
